// File: rtl/csr_encoder.sv
// Sparse-row encoder: scans dense rows one column per cycle and packs the nonzeros
// into CSR arrays (col_idx, value, node_info) that are presented once per frame.
module csr_encoder #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned H_NUM_OF_COLS   = 5,
  parameter int unsigned COL_INDEX_SIZE  = 8,
  parameter int unsigned VALUE_SIZE      = COL_INDEX_SIZE,
  parameter int unsigned NODE_INFO_SIZE  = 5,
  parameter int unsigned COL_IDX_WIDTH   = $clog2(H_NUM_OF_COLS),
  parameter int unsigned INDEX_WIDTH     = $clog2(COL_INDEX_SIZE),
  parameter int unsigned ROW_LEN_WIDTH   = $clog2(H_NUM_OF_COLS),
  parameter int unsigned NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       row_valid_i,
  output logic                       row_ready_o,
  input  logic                       row_last_i,
  input  logic [DATA_WIDTH-1:0]      row_i       [0:H_NUM_OF_COLS-1],
  output logic                       h_valid_o,
  output logic [COL_IDX_WIDTH-1:0]   col_idx_o   [0:COL_INDEX_SIZE-1],
  output logic [DATA_WIDTH-1:0]      value_o     [0:VALUE_SIZE-1],
  output logic [NODE_INFO_WIDTH-1:0] node_info_o [0:NODE_INFO_SIZE-1],
  output logic                       overflow_o
);

  localparam int unsigned NnzW = $clog2(COL_INDEX_SIZE + 1);
  localparam int unsigned RowW = $clog2(NODE_INFO_SIZE + 1);
  localparam logic [NnzW-1:0]          NnzMax  = NnzW'(COL_INDEX_SIZE);
  localparam logic [RowW-1:0]          RowMax  = RowW'(NODE_INFO_SIZE);
  localparam logic [COL_IDX_WIDTH-1:0] LastCol = COL_IDX_WIDTH'(H_NUM_OF_COLS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      row_q [0:H_NUM_OF_COLS-1];
  logic                       last_q;
  logic [INDEX_WIDTH-1:0]     index_q;
  logic [NnzW-1:0]            nnz_q;
  logic [RowW-1:0]            row_cnt_q;
  logic [COL_IDX_WIDTH-1:0]   col_q;
  logic [ROW_LEN_WIDTH-1:0]   len_q;
  logic                       ovf_q;
  logic [COL_IDX_WIDTH-1:0]   col_idx_q   [0:COL_INDEX_SIZE-1];
  logic [DATA_WIDTH-1:0]      value_q     [0:VALUE_SIZE-1];
  logic [NODE_INFO_WIDTH-1:0] node_info_q [0:NODE_INFO_SIZE-1];

  logic                     accept;
  logic [DATA_WIDTH-1:0]    elem;
  logic                     nonzero;
  logic                     store;
  logic                     drop;
  logic                     col_end;
  logic [ROW_LEN_WIDTH-1:0] len_end;

  always_comb begin
    accept  = (state_q == StIdle) && row_valid_i;
    elem    = row_q[col_q];
    nonzero = |elem;
    store   = (state_q == StScan) && nonzero && (nnz_q < NnzMax);
    drop    = (state_q == StScan) && nonzero && !(nnz_q < NnzMax);
    col_end = (state_q == StScan) && (col_q == LastCol);
    // Row length includes the element stored on the final column cycle.
    len_end = len_q + ROW_LEN_WIDTH'(store);
  end

  always_comb begin
    state_d     = state_q;
    row_ready_o = 1'b0;
    h_valid_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        row_ready_o = 1'b1;
        if (row_valid_i) state_d = StScan;
      end
      StScan: begin
        if (col_q == LastCol) state_d = last_q ? StDone : StIdle;
      end
      StDone: begin
        h_valid_o = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < H_NUM_OF_COLS; c++) row_q[c] <= '0;
      for (int i = 0; i < COL_INDEX_SIZE; i++) col_idx_q[i] <= '0;
      for (int i = 0; i < VALUE_SIZE; i++) value_q[i] <= '0;
      for (int i = 0; i < NODE_INFO_SIZE; i++) node_info_q[i] <= '0;
      last_q    <= 1'b0;
      index_q   <= '0;
      nnz_q     <= '0;
      row_cnt_q <= '0;
      col_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        row_q   <= row_i;
        last_q  <= row_last_i;
        index_q <= nnz_q[INDEX_WIDTH-1:0];
        col_q   <= '0;
        len_q   <= '0;
        // First row of a frame wipes the previous frame's results.
        if (row_cnt_q == '0) begin
          for (int i = 0; i < COL_INDEX_SIZE; i++) col_idx_q[i] <= '0;
          for (int i = 0; i < VALUE_SIZE; i++) value_q[i] <= '0;
          for (int i = 0; i < NODE_INFO_SIZE; i++) node_info_q[i] <= '0;
          ovf_q <= 1'b0;
        end
      end
      if (state_q == StScan) begin
        col_q <= col_q + COL_IDX_WIDTH'(1);
        if (store) begin
          col_idx_q[nnz_q[INDEX_WIDTH-1:0]] <= col_q;
          value_q[nnz_q[INDEX_WIDTH-1:0]]   <= elem;
          nnz_q <= nnz_q + NnzW'(1);
          len_q <= len_q + ROW_LEN_WIDTH'(1);
        end
        if (drop) ovf_q <= 1'b1;
        if (col_end) begin
          if (row_cnt_q < RowMax) begin
            node_info_q[row_cnt_q] <= {index_q, len_end, last_q};
          end else begin
            ovf_q <= 1'b1;
          end
          // Saturate so very long frames never alias back to a frame start.
          if (row_cnt_q != RowMax) row_cnt_q <= row_cnt_q + RowW'(1);
        end
      end
      if (state_q == StDone) begin
        row_cnt_q <= '0;
        nnz_q     <= '0;
      end
    end
  end

  assign col_idx_o   = col_idx_q;
  assign value_o     = value_q;
  assign node_info_o = node_info_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_csr_encoder.sv
// Randomized and directed bench for csr_encoder, checked against a frame-level CSR model.
module tb_csr_encoder;

  localparam int DW  = 8;
  localparam int H   = 5;
  localparam int CS  = 8;
  localparam int NS  = 5;
  localparam int CW  = $clog2(H);
  localparam int IW  = $clog2(CS);
  localparam int RLW = $clog2(H);
  localparam int NW  = IW + RLW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          row_valid_i = 1'b0;
  logic          row_ready_o;
  logic          row_last_i = 1'b0;
  logic [DW-1:0] row_i [0:H-1];
  logic          h_valid_o;
  logic [CW-1:0] col_idx_o [0:CS-1];
  logic [DW-1:0] value_o [0:CS-1];
  logic [NW-1:0] node_info_o [0:NS-1];
  logic          overflow_o;

  csr_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_valid_i (row_valid_i),
    .row_ready_o (row_ready_o),
    .row_last_i  (row_last_i),
    .row_i       (row_i),
    .h_valid_o   (h_valid_o),
    .col_idx_o   (col_idx_o),
    .value_o     (value_o),
    .node_info_o (node_info_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rows [8][H];
  int exp_col [CS];
  int exp_val [CS];
  int exp_node [NS];
  int exp_ovf;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c, input int d,
                         input int e);
    rows[r][0] = a; rows[r][1] = b; rows[r][2] = c; rows[r][3] = d; rows[r][4] = e;
  endtask

  function automatic int pack_node(input int idx, input int len, input int flag);
    return ((idx % (1 << IW)) << (RLW + 1)) | ((len % (1 << RLW)) << 1) | flag;
  endfunction

  // Whole-frame CSR construction straight from the packing rules.
  task automatic build_model(input int n);
    int nnz, len, idx;
    for (int i = 0; i < CS; i++) begin exp_col[i] = 0; exp_val[i] = 0; end
    for (int i = 0; i < NS; i++) exp_node[i] = 0;
    exp_ovf = 0;
    nnz = 0;
    for (int r = 0; r < n; r++) begin
      idx = nnz;
      len = 0;
      for (int c = 0; c < H; c++) begin
        if (rows[r][c] != 0) begin
          if (nnz < CS) begin
            exp_col[nnz] = c; exp_val[nnz] = rows[r][c]; nnz++; len++;
          end else exp_ovf = 1;
        end
      end
      if (r < NS) exp_node[r] = pack_node(idx, len, (r == n - 1) ? 1 : 0);
      else exp_ovf = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < CS; i++) begin
      check_eq($sformatf("%s col_idx[%0d]", tag, i), int'(col_idx_o[i]), exp_col[i]);
      check_eq($sformatf("%s value[%0d]", tag, i), int'(value_o[i]), exp_val[i]);
    end
    for (int i = 0; i < NS; i++)
      check_eq($sformatf("%s node_info[%0d]", tag, i), int'(node_info_o[i]), exp_node[i]);
    check_eq($sformatf("%s overflow", tag), int'(overflow_o), exp_ovf);
  endtask

  task automatic check_nominal_consts();
    int ncol [CS] = '{0, 4, 2, 4, 1, 3, 2, 4};
    int nval [CS] = '{2, 9, 7, 8, 6, 5, 3, 1};
    int nidx [NS] = '{0, 2, 4, 6, 7};
    int nlen [NS] = '{2, 2, 2, 1, 1};
    for (int i = 0; i < CS; i++) begin
      check_eq($sformatf("nom col_idx[%0d]", i), int'(col_idx_o[i]), ncol[i]);
      check_eq($sformatf("nom value[%0d]", i), int'(value_o[i]), nval[i]);
    end
    for (int i = 0; i < NS; i++) begin
      check_eq($sformatf("nom index[%0d]", i), int'(node_info_o[i][NW-1 -: IW]), nidx[i]);
      check_eq($sformatf("nom row_len[%0d]", i), int'(node_info_o[i][RLW:1]), nlen[i]);
      check_eq($sformatf("nom flag[%0d]", i), int'(node_info_o[i][0]), (i == NS - 1) ? 1 : 0);
    end
    check_eq("nom overflow", int'(overflow_o), 0);
  endtask

  task automatic set_nominal();
    set_row(0, 2, 0, 0, 0, 9);
    set_row(1, 0, 0, 7, 0, 8);
    set_row(2, 0, 6, 0, 5, 0);
    set_row(3, 0, 0, 3, 0, 0);
    set_row(4, 0, 0, 0, 0, 1);
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!row_ready_o && waited < 4 * H) begin
      check_eq("no early h_valid", int'(h_valid_o), 0);
      @(negedge clk);
      waited++;
    end
    check_eq("row_ready", int'(row_ready_o), 1);
  endtask

  // Drives n rows from rows[], checks handshake timing, then the arrays at the h_valid pulse.
  task automatic run_frame(input string tag, input int n, input int gap);
    int prev_acc = 0;
    int waited;
    build_model(n);
    for (int r = 0; r < n; r++) begin
      wait_ready();
      if (r > 0 && gap > 0) begin
        repeat (gap) begin
          @(negedge clk);
          check_eq("stall ready", int'(row_ready_o), 1);
        end
      end
      if (r > 0 && gap == 0) check_eq("accept spacing", cyc - prev_acc, H + 1);
      prev_acc = cyc;
      for (int c = 0; c < H; c++) row_i[c] = DW'(rows[r][c]);
      row_valid_i = 1'b1;
      row_last_i  = (r == n - 1);
      @(negedge clk);
      check_eq("ready low in scan", int'(row_ready_o), 0);
      if (gap > 0 || r == n - 1) row_valid_i = 1'b0;
    end
    waited = 0;
    while (!h_valid_o && waited < 4 * H) begin
      @(negedge clk);
      waited++;
    end
    check_eq($sformatf("%s h_valid latency", tag), cyc - prev_acc, H + 1);
    check_outputs(tag);
    if (tag == "nominal") check_nominal_consts();
    @(negedge clk);
    check_eq("h_valid one cycle", int'(h_valid_o), 0);
    check_eq("ready after done", int'(row_ready_o), 1);
  endtask

  task automatic check_all_zero(input string tag);
    int acc = 0;
    for (int i = 0; i < CS; i++) acc |= int'(col_idx_o[i]) | int'(value_o[i]);
    for (int i = 0; i < NS; i++) acc |= int'(node_info_o[i]);
    check_eq($sformatf("%s arrays zero", tag), acc, 0);
    check_eq($sformatf("%s ready", tag), int'(row_ready_o), 1);
    check_eq($sformatf("%s h_valid", tag), int'(h_valid_o), 0);
    check_eq($sformatf("%s overflow", tag), int'(overflow_o), 0);
  endtask

  initial begin
    int n, gap, hv_seen;
    for (int c = 0; c < H; c++) row_i[c] = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_nominal();
    run_frame("nominal", 5, 0);

    set_row(0, 1, 2, 3, 4, 5);
    set_row(1, 6, 7, 8, 9, 10);
    run_frame("nnz overflow", 2, 0);
    check_eq("nnz ovf node1", int'(node_info_o[1]), pack_node(5, 3, 1));

    for (int r = 0; r < 6; r++) set_row(r, 0, 0, 0, 0, 1);
    run_frame("row overflow", 6, 0);
    check_eq("row ovf node4", int'(node_info_o[4]), pack_node(4, 1, 0));

    set_row(0, 0, 0, 0, 0, 0);
    set_row(1, 5, 0, 0, 0, 0);
    run_frame("empty row", 2, 0);
    check_eq("empty node1", int'(node_info_o[1]), pack_node(0, 1, 1));

    set_nominal();
    run_frame("stalled", 5, 3);

    // Abort a frame mid-scan; nothing from it may survive.
    set_nominal();
    wait_ready();
    for (int c = 0; c < H; c++) row_i[c] = DW'(rows[0][c]);
    row_valid_i = 1'b1;
    row_last_i  = 1'b0;
    @(negedge clk);
    row_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-scan reset");
    @(negedge clk);
    rst_n = 1'b1;
    hv_seen = 0;
    repeat (3 * H) begin
      @(negedge clk);
      hv_seen |= int'(h_valid_o);
    end
    check_eq("no h_valid after reset", hv_seen, 0);

    set_nominal();
    run_frame("nominal", 5, 0);

    for (int f = 0; f < 30; f++) begin
      n   = $urandom_range(1, 7);
      gap = $urandom_range(0, 2);
      for (int r = 0; r < n; r++)
        for (int c = 0; c < H; c++)
          rows[r][c] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 255) : 0;
      run_frame($sformatf("rand%0d", f), n, gap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_encoder.md
Name: csr_encoder

Overview:
- Producer side of the sparse feature-matrix interface consumed by the scheduler.
- Accepts dense H rows one at a time and scans them one column per cycle.
- Packs the nonzero elements into CSR arrays: col_idx, value and node_info = {index, row_len, flag}.
- When the frame's last row is done, presents the arrays with a one-cycle h_valid_o pulse.

Parameters:
- DATA_WIDTH, 8, element and value width.
- H_NUM_OF_COLS, 5, dense row length (dot-product size).
- COL_INDEX_SIZE, 8, capacity of the col_idx/value arrays (max nonzeros per frame).
- VALUE_SIZE, COL_INDEX_SIZE, value array depth; must equal COL_INDEX_SIZE.
- NODE_INFO_SIZE, 5, max rows per frame.
- COL_IDX_WIDTH, $clog2(H_NUM_OF_COLS), column index width.
- INDEX_WIDTH, $clog2(COL_INDEX_SIZE), start index width.
- ROW_LEN_WIDTH, $clog2(H_NUM_OF_COLS), row length width.
- NODE_INFO_WIDTH, INDEX_WIDTH+ROW_LEN_WIDTH+1, packed {index, row_len, flag}.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- row_valid_i  in  1  dense row present.
- row_ready_o  out  1  encoder can accept a row.
- row_last_i  in  1  accepted row is the last of the frame.
- row_i  in  [0:H_NUM_OF_COLS-1] x DATA_WIDTH  dense row.
- h_valid_o  out  1  one-cycle pulse: CSR arrays complete.
- col_idx_o  out  [0:COL_INDEX_SIZE-1] x COL_IDX_WIDTH  column of each nonzero.
- value_o  out  [0:VALUE_SIZE-1] x DATA_WIDTH  nonzero values.
- node_info_o  out  [0:NODE_INFO_SIZE-1] x NODE_INFO_WIDTH  per-row {index, row_len, flag}.
- overflow_o  out  1  sticky: frame exceeded capacity.

Behaviour:
- Reset (async, immediate):
  - state IDLE, row_ready_o=1, h_valid_o=0, overflow_o=0.
  - All arrays, nnz counter, row counter and column counter = 0.
  - A reset mid-frame discards the frame. No h_valid_o is produced for it.
- FSM IDLE:
  - row_ready_o=1.
  - Handshake when row_valid_i & row_ready_o at edge T: latch row_i and row_last_i, latch index = nnz counter, go to SCAN.
  - If the row counter is 0 (frame start), on the same edge clear every array entry to 0 and clear overflow_o.
- FSM SCAN:
  - row_ready_o=0 for H_NUM_OF_COLS cycles (T+1 .. T+H_NUM_OF_COLS). Column c is examined in cycle T+1+c.
  - For a nonzero element, when nnz < COL_INDEX_SIZE: col_idx_o[nnz]=c, value_o[nnz]=element, nnz++.
  - For a nonzero element when nnz = COL_INDEX_SIZE: the element is dropped and overflow_o is set.
  - row_len counts only the nonzeros actually stored.
- End of scan (last column cycle):
  - If the row counter < NODE_INFO_SIZE, write node_info_o[row] = {index, row_len, flag}, where flag=1 iff row_last_i was latched. Otherwise drop the entry and set overflow_o.
  - Increment the row counter.
  - If last: go to DONE. Else: go to IDLE, with row_ready_o=1 in cycle T+H_NUM_OF_COLS+1.
- FSM DONE:
  - One cycle at T+H_NUM_OF_COLS+1: h_valid_o=1, row_ready_o=0.
  - Reset the row and nnz counters, then return to IDLE.
  - Outputs stay stable until the next frame start.
- Empty row (all zero): node_info = {nnz, 0, flag}. Still consumes one node_info slot.
- Zero test is on the full DATA_WIDTH bits. Values are unsigned bit patterns, stored as-is.
- Width truncation:
  - row_len = H_NUM_OF_COLS or index = COL_INDEX_SIZE wraps modulo field width when the size is a power of two.
  - For this reason, integrators keep H_NUM_OF_COLS a non-power-of-two, or accept the wrap.
- Per-row latency is H_NUM_OF_COLS+1 cycles, so back-to-back rows are accepted every H_NUM_OF_COLS+1 cycles.
- Frame latency: last-row handshake to h_valid_o is H_NUM_OF_COLS+1 cycles.

Test Plan:
- Nominal frame (defaults, row_valid_i held high):
  - Stimulus: rows [2,0,0,0,9], [0,0,7,0,8], [0,6,0,5,0], [0,0,3,0,0], [0,0,0,0,1]; last on row 4.
  - Required: accepts at cycles 0, 6, 12, 18, 24; h_valid_o only at cycle 30.
  - Required arrays: col_idx = {0,4,2,4,1,3,2,4}, value = {2,9,7,8,6,5,3,1}, node_info = {(0,2,0), (2,2,0), (4,2,0), (6,1,0), (7,1,1)}.
  - Required: overflow_o=0.
- Empty row and short frame:
  - Stimulus: rows [0,0,0,0,0], then [5,0,0,0,0] with last.
  - Required: node_info[0] = (0,0,0), node_info[1] = (0,1,1), col_idx[0]=0, value[0]=5, remaining entries 0.
- Nonzero overflow:
  - Stimulus: rows [1,2,3,4,5], then [6,7,8,9,10] with last.
  - Required: value = {1,2,3,4,5,6,7,8}, node_info[1] = (5,3,1), overflow_o=1 at the h_valid_o pulse.
- Row overflow:
  - Stimulus: 6 rows [0,0,0,0,1], last on the 6th.
  - Required: node_info[4] = (4,1,0), 6th row dropped, overflow_o=1.
  - Required: h_valid_o still pulses, and no node_info entry has flag=1.
- Back-pressure, reset and next frame:
  - Stimulus: stall row_valid_i for 3 cycles between rows, then assert rst_n=0 mid-SCAN.
  - Required: stall leaves the arrays unchanged. Reset gives immediate row_ready_o=1, all outputs 0, no h_valid_o.
  - Required: a following nominal frame reproduces scenario 1 exactly, including clearing of stale entries.
